adder_pipe: RTL and testbench

- Parametrised, pipelined two's-complement add/subtract unit.
- Next generation of the team's fixed-width ripple-carry adder chain: operands are split into STAGE_W-bit chunks, and one chunk is resolved per pipeline stage with the carry registered between stages.
- Adds subtract mode, optional signed saturation, status flags and a valid/ready stream handshake.
- Sits between the ALU operand latch and result writeback.

---
 rtl/adder_pipe.sv | 129 ++++++++++++
 tb/tb_adder_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined chunked two's-complement add/subtract with saturation and flags
// One STAGE_W-bit chunk is resolved per stage; the last chunk resolves straight into the output register.
module adder_pipe #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int STAGES = WIDTH / STAGE_W;
  localparam int LO     = (STAGES - 1) * STAGE_W;

  if (STAGE_W < 1 || WIDTH < 2 || (WIDTH % STAGE_W) != 0) begin : g_bad_params
    $error("adder_pipe: WIDTH must be >= 2 and a multiple of STAGE_W");
  end

  // bp is the already-conditioned operand B' and cy the carry into the next unresolved chunk,
  // so subtract mode is fully folded in at the first stage.
  typedef struct packed {
    logic             vld;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] ps;
    logic             cy;
  } beat_t;

  function automatic logic [STAGE_W:0] chunk_add(input beat_t bt, input int c);
    return {1'b0, bt.a[c*STAGE_W +: STAGE_W]} + {1'b0, bt.bp[c*STAGE_W +: STAGE_W]}
           + (STAGE_W+1)'(bt.cy);
  endfunction

  logic advance;
  logic out_valid_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  beat_t [STAGES-1:0] stg_in;

  assign stg_in[0] = {in_valid, sat, a, (sub ? ~b : b), {WIDTH{1'b0}}, sub};

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    beat_t beat_d;
    beat_t beat_q;

    always_comb begin
      beat_d = stg_in[k-1];
      {beat_d.cy, beat_d.ps[(k-1)*STAGE_W +: STAGE_W]} = chunk_add(stg_in[k-1], k - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        beat_q <= '0;
      end else if (advance) begin
        beat_q <= beat_d;
      end
    end

    assign stg_in[k] = beat_q;
  end

  beat_t            last;
  logic [STAGE_W:0] fin_chunk;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] fin_sum;
  logic             raw_ovf;

  assign last      = stg_in[STAGES-1];
  assign fin_chunk = chunk_add(last, STAGES - 1);

  always_comb begin
    raw                  = last.ps;
    raw[LO +: STAGE_W]   = fin_chunk[STAGE_W-1:0];
    raw_ovf              = (last.a[WIDTH-1] == last.bp[WIDTH-1]) && (raw[WIDTH-1] != last.a[WIDTH-1]);
    fin_sum              = raw;
    if (last.sat && raw_ovf) begin
      fin_sum = last.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  // Result fields only load on a valid beat so they keep their reset/last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= last.vld;
      if (last.vld) begin
        sum_q  <= fin_sum;
        cout_q <= fin_chunk[STAGE_W];
        ovf_q  <= raw_ovf;
        zero_q <= (fin_sum == '0);
        neg_q  <= fin_sum[WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed and randomized self-checking bench for adder_pipe
// Results are scoreboarded against an integer-arithmetic model of add/sub/saturate.
module tb_adder_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, zero, neg;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_in = 0;
  int          n_out = 0;
  logic [19:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [19:0] hold_val = '0;
  logic [15:0] hv;

  adder_pipe #(.WIDTH(16), .STAGE_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {zero, neg, ovf, cout, sum}.
  function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sv, input logic tv);
    int          tru;
    int unsigned u;
    logic [15:0] r;
    logic        c, o;
    if (sv) begin
      tru = int'($signed(av)) - int'($signed(bv));
      u   = 32'(av) + (32'hFFFF - 32'(bv)) + 32'd1;
    end else begin
      tru = int'($signed(av)) + int'($signed(bv));
      u   = 32'(av) + 32'(bv);
    end
    r = u[15:0];
    c = u[16];
    o = (tru > 32767) || (tru < -32768);
    if (tv && o) r = (tru > 0) ? 16'h7FFF : 16'h8000;
    return {(r == 16'h0000), r[15], o, c, r};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_pend) check("stable", {zero, neg, ovf, cout, sum}, hold_val);
        if (out_ready) begin
          if (exp_q.size() == 0) check("extra_result", 1, 0);
          else check("result", {zero, neg, ovf, cout, sum}, exp_q.pop_front());
          n_out++;
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_val  = {zero, neg, ovf, cout, sum};
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, sat));
        n_in++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic tv, input logic [19:0] expv);
    int lat;
    a = av; b = bv; sub = sv; sat = tv; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 4);
    check("directed", {zero, neg, ovf, cout, sum}, expv);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out, cyc, g;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {zero, neg, ovf, cout, sum}, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_hold_outputs", {out_valid, zero, neg, ovf, cout, sum}, 0);

    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 1'b0, 16'h8000});
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF});
    run_one(16'h0005, 16'h0007, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE});
    run_one(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 1'b1, 16'h8000});
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    run_one(16'h1234, 16'h1234, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    drain("directed_drain");

    out_ready = 1'b1;
    base_out  = n_out;
    fork
      begin : drv
        logic acc;
        int   gd;
        for (int i = 1; i <= 6; i++) begin
          a = 16'(i); b = 16'(i); sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
          gd = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            gd++;
          end while (!acc && gd < 50);
        end
        in_valid = 1'b0;
      end
      begin : hold
        int gh;
        gh = 0;
        while (!out_valid && gh < 50) begin
          tick();
          gh++;
        end
        check("s4_first_valid", out_valid, 1);
        check("s4_first_sum", sum, 16'h0002);
        out_ready = 1'b0;
        hv = sum;
        repeat (3) begin
          @(negedge clk);
          check("s4_in_ready_low", in_ready, 0);
          check("s4_hold_sum", sum, hv);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain("s4_drain");
    check("s4_count", n_out - base_out, 6);

    out_ready = 1'b0;
    a = 16'h0011; b = 16'h0022; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h0100; b = 16'h0200;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    check("s5_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("s5_valid_drop", out_valid, 0);
    check("s5_sum_clear", sum, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      tick();
      check("s5_quiet", out_valid, 0);
    end
    run_one(16'h0003, 16'h0004, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 1'b0, 16'h0007});
    drain("s5_drain");

    base_in  = n_in;
    base_out = n_out;
    cyc      = 0;
    while ((n_in - base_in) < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      sub       = 1'($urandom_range(0, 1));
      sat       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("s6_drain");
    check("s6_beats", n_in - base_in, 1000);
    check("s6_delivered", n_out - base_out, n_in - base_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
